// File: rtl/read_controller.sv
`timescale 1ns/1ps
// Frame read-back: walks pixel BRAM 0..NUM_PIXELS-1, sends each pixel as 3 bytes (MSB first) to uart_tx.
// Latency: en one cycle after start; first tx_start RD_LATENCY+2 cycles after the en cycle when tx is idle.
// Backpressure: holds in SEND while tx_busy=1; at most one byte outstanding, start ignored while busy.
module read_controller #(
  parameter int NUM_PIXELS = 196608,
  parameter int ADDR_W     = 18,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [23:0]       dout,
  input  logic              tx_busy,
  output logic              en,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        status
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    LATCH   = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    NEXT    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  // Counter value in the cycle where BRAM dout becomes valid (counter is 0 in the first LATCH cycle).
  localparam logic [1:0]        LAT_LAST  = 2'(RD_LATENCY - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              en_nxt, tx_start_nxt, busy_nxt, done_nxt;
  logic [7:0]        tx_data_nxt;
  logic [23:0]       pixel, pixel_nxt;
  logic [1:0]        byte_idx, byte_idx_nxt;
  logic [1:0]        lat_cnt, lat_cnt_nxt;

  assign we     = 1'b0;
  assign status = state;

  // State and registered outputs; all clear immediately on reset, aborting any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      en       <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pixel    <= 24'd0;
      byte_idx <= 2'd0;
      lat_cnt  <= 2'd0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      en       <= en_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      pixel    <= pixel_nxt;
      byte_idx <= byte_idx_nxt;
      lat_cnt  <= lat_cnt_nxt;
    end
  end

  // Next-state and next-output logic; en/tx_start/done are single-cycle pulses by default.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    en_nxt       = 1'b0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    pixel_nxt    = pixel;
    byte_idx_nxt = byte_idx;
    lat_cnt_nxt  = lat_cnt;
    case (state)
      IDLE: begin
        addr_nxt = '0;
        // A start landing on the done cycle belongs to the finished frame and is dropped.
        if (start && !done) begin
          state_nxt = READ;
          busy_nxt  = 1'b1;
          en_nxt    = 1'b1;
        end
      end
      READ: begin
        lat_cnt_nxt = 2'd0;
        state_nxt   = LATCH;
      end
      LATCH: begin
        if (lat_cnt == LAT_LAST) begin
          pixel_nxt    = dout;
          byte_idx_nxt = 2'd0;
          state_nxt    = SEND;
        end else begin
          lat_cnt_nxt = lat_cnt + 2'd1;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_nxt = 1'b1;
          case (byte_idx)
            2'd0:    tx_data_nxt = pixel[23:16];
            2'd1:    tx_data_nxt = pixel[15:8];
            default: tx_data_nxt = pixel[7:0];
          endcase
          state_nxt = WAIT_TX;
        end
      end
      WAIT_TX: begin
        // tx_start is high only in the first WAIT_TX cycle: uart_tx has not raised busy yet.
        if (!tx_start && !tx_busy) state_nxt = NEXT;
      end
      NEXT: begin
        if (byte_idx != 2'd2) begin
          byte_idx_nxt = byte_idx + 2'd1;
          state_nxt    = SEND;
        end else if (addr == LAST_ADDR) begin
          addr_nxt  = '0;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          addr_nxt  = addr + ADDR_W'(1);
          en_nxt    = 1'b1;
          state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_read_controller.sv
`timescale 1ns/1ps
// Bench for read_controller: three instances with RD_LATENCY 1, 2, 3 on a 4-pixel frame.
// Each has its own BRAM pipeline model (X outside the valid cycle) and a uart_tx busy model.
// Instance 1 (RD_LATENCY=2) carries the main scenarios.
module tb_read_controller;

  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_w    [3];
  logic [23:0] dout_w     [3];
  logic        tx_busy_w  [3];
  logic        en_w       [3];
  logic        we_w       [3];
  logic [17:0] addr_w     [3];
  logic        tx_start_w [3];
  logic [7:0]  tx_data_w  [3];
  logic        busy_w     [3];
  logic        done_w     [3];
  logic [2:0]  status_w   [3];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      read_controller #(.NUM_PIXELS(NP), .ADDR_W(18), .RD_LATENCY(gi + 1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_w[gi]), .dout(dout_w[gi]),
        .tx_busy(tx_busy_w[gi]), .en(en_w[gi]), .we(we_w[gi]), .addr(addr_w[gi]),
        .tx_start(tx_start_w[gi]), .tx_data(tx_data_w[gi]), .busy(busy_w[gi]),
        .done(done_w[gi]), .status(status_w[gi])
      );
    end
  endgenerate

  // Models and monitors
  logic [23:0] mem    [4];
  logic [23:0] d_pipe [3][3];
  logic        v_pipe [3][3];
  int          tx_cnt [3];
  logic        hold   [3];
  logic        rnd_mode;
  logic        clr;
  logic [7:0]  rx_mem [3][64];
  int          rx_cnt [3];
  logic [17:0] en_addr[3][16];
  int          en_cnt [3];
  int          done_cnt[3];
  int          viol   [3];

  int n_chk  = 0;
  int n_fail = 0;

  always_comb begin
    for (int g = 0; g < 3; g++) begin
      tx_busy_w[g] = (tx_cnt[g] != 0) || hold[g];
      dout_w[g]    = v_pipe[g][g] ? d_pipe[g][g] : 24'hxxxxxx;
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      d_pipe[g][0] <= mem[addr_w[g][1:0]];
      v_pipe[g][0] <= en_w[g];
      for (int i = 1; i < 3; i++) begin
        d_pipe[g][i] <= d_pipe[g][i-1];
        v_pipe[g][i] <= v_pipe[g][i-1];
      end
      if (clr) begin
        rx_cnt[g] <= 0; en_cnt[g] <= 0; done_cnt[g] <= 0; viol[g] <= 0; tx_cnt[g] <= 0;
      end else begin
        if (tx_start_w[g]) begin
          if (tx_busy_w[g]) viol[g] <= viol[g] + 1;
          if (rx_cnt[g] < 64) rx_mem[g][rx_cnt[g]] <= tx_data_w[g];
          rx_cnt[g] <= rx_cnt[g] + 1;
          tx_cnt[g] <= rnd_mode ? int'($urandom_range(12, 1)) : 10;
        end else if (tx_cnt[g] != 0) begin
          tx_cnt[g] <= tx_cnt[g] - 1;
        end
        if (en_w[g]) begin
          if (en_cnt[g] < 16) en_addr[g][en_cnt[g]] <= addr_w[g];
          en_cnt[g] <= en_cnt[g] + 1;
        end
        if (done_w[g]) done_cnt[g] <= done_cnt[g] + 1;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int k);
    logic [23:0] px;
    logic [23:0] sh;
    case (k / 3)
      0:       px = 24'h112233;
      1:       px = 24'h445566;
      2:       px = 24'h778899;
      default: px = 24'hAABBCC;
    endcase
    sh = px >> (8 * (2 - (k % 3)));
    return sh[7:0];
  endfunction

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk); start_w[g] = 1'b1;
    @(negedge clk); start_w[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, output bit ok);
    int k = 0;
    while (!done_w[g] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    ok = done_w[g];
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if ({en_w[g], we_w[g], tx_start_w[g], busy_w[g], done_w[g]} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_ctl[%0d]: got %b want 00000", g,
                 {en_w[g], we_w[g], tx_start_w[g], busy_w[g], done_w[g]});
      end
      n_chk++;
      if (addr_w[g] !== 18'd0 || tx_data_w[g] !== 8'd0 || status_w[g] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: addr %h data %h status %0d, want 0 0 0", g,
                 addr_w[g], tx_data_w[g], status_w[g]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    do_clr();
    n_chk++;
    if (status_w[1] !== 3'd0 || busy_w[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: status %0d busy %b, want 0 0", status_w[1], busy_w[1]);
    end
    // Asynchronous clear mid-frame, mid-cycle
    pulse_start(1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (status_w[1] !== 3'd0 || busy_w[1] !== 1'b0 || en_w[1] !== 1'b0 || tx_start_w[1] !== 1'b0
        || addr_w[1] !== 18'd0) begin
      n_fail++;
      $display("FAIL async_reset: status %0d busy %b en %b tx_start %b addr %h, want all 0",
               status_w[1], busy_w[1], en_w[1], tx_start_w[1], addr_w[1]);
    end
    @(negedge clk); rst_n = 1'b1;
    do_clr();
    ok = 1'b1;
  endtask

  task automatic test_frame();
    bit ok;
    do_clr();
    pulse_start(1);
    n_chk++;
    if (busy_w[1] !== 1'b1 || en_w[1] !== 1'b1 || status_w[1] !== 3'd1) begin
      n_fail++;
      $display("FAIL frame_accept: busy %b en %b status %0d, want 1 1 1", busy_w[1], en_w[1], status_w[1]);
    end
    wait_done(1, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL frame_done_timeout: got no done, want done"); end
    n_chk++;
    if (addr_w[1] !== 18'd0 || busy_w[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end: addr %h busy %b, want 0 0", addr_w[1], busy_w[1]);
    end
    @(negedge clk);
    n_chk++;
    if (done_w[1] !== 1'b0 || done_cnt[1] !== 1) begin
      n_fail++;
      $display("FAIL frame_done_pulse: done %b count %0d, want 0 1", done_w[1], done_cnt[1]);
    end
    n_chk++;
    if (rx_cnt[1] !== 12 || en_cnt[1] !== 4 || viol[1] !== 0) begin
      n_fail++;
      $display("FAIL frame_counts: bytes %0d en %0d viol %0d, want 12 4 0", rx_cnt[1], en_cnt[1], viol[1]);
    end
    for (int k = 0; k < 12; k++) begin
      n_chk++;
      if (rx_mem[1][k] !== exp_byte(k)) begin
        n_fail++;
        $display("FAIL frame_byte %0d: got %h want %h", k, rx_mem[1][k], exp_byte(k));
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (en_addr[1][k] !== 18'(k)) begin
        n_fail++;
        $display("FAIL frame_en_addr %0d: got %h want %h", k, en_addr[1][k], 18'(k));
      end
    end
  endtask

  task automatic test_latency();
    int k = 0;
    do_clr();
    @(negedge clk); start_w[0] = 1'b1; start_w[2] = 1'b1;
    @(negedge clk); start_w[0] = 1'b0; start_w[2] = 1'b0;
    while ((done_cnt[0] == 0 || done_cnt[2] == 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    for (int g = 0; g < 3; g += 2) begin
      n_chk++;
      if (done_cnt[g] !== 1 || rx_cnt[g] !== 12) begin
        n_fail++;
        $display("FAIL lat%0d_counts: done %0d bytes %0d, want 1 12", g + 1, done_cnt[g], rx_cnt[g]);
      end
      for (int b = 0; b < 12; b++) begin
        n_chk++;
        if (rx_mem[g][b] !== exp_byte(b)) begin
          n_fail++;
          $display("FAIL lat%0d_byte %0d: got %h want %h", g + 1, b, rx_mem[g][b], exp_byte(b));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_clr();
    hold[1] = 1'b1;
    rnd_mode = 1'b1;
    pulse_start(1);
    repeat (50) @(negedge clk);
    n_chk++;
    if (rx_cnt[1] !== 0 || status_w[1] !== 3'd3) begin
      n_fail++;
      $display("FAIL bp_hold: bytes %0d status %0d, want 0 3", rx_cnt[1], status_w[1]);
    end
    hold[1] = 1'b0;
    wait_done(1, ok);
    @(negedge clk);
    n_chk++;
    if (!ok || rx_cnt[1] !== 12 || viol[1] !== 0) begin
      n_fail++;
      $display("FAIL bp_counts: done %b bytes %0d viol %0d, want 1 12 0", ok, rx_cnt[1], viol[1]);
    end
    for (int k = 0; k < 12; k++) begin
      n_chk++;
      if (rx_mem[1][k] !== exp_byte(k)) begin
        n_fail++;
        $display("FAIL bp_byte %0d: got %h want %h", k, rx_mem[1][k], exp_byte(k));
      end
    end
    rnd_mode = 1'b0;
  endtask

  task automatic test_start_ignored();
    bit ok;
    do_clr();
    pulse_start(1);
    repeat (30) @(negedge clk);
    pulse_start(1);
    wait_done(1, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL ign_done_timeout: got no done, want done"); end
    start_w[1] = 1'b1;          // coincident with done
    @(negedge clk);
    n_chk++;
    if (status_w[1] !== 3'd0 || busy_w[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_on_done: status %0d busy %b, want 0 0", status_w[1], busy_w[1]);
    end
    @(negedge clk); start_w[1] = 1'b0;   // start held one cycle past done is accepted
    n_chk++;
    if (status_w[1] !== 3'd1 || busy_w[1] !== 1'b1 || en_w[1] !== 1'b1 || addr_w[1] !== 18'd0) begin
      n_fail++;
      $display("FAIL ign_restart: status %0d busy %b en %b addr %h, want 1 1 1 0",
               status_w[1], busy_w[1], en_w[1], addr_w[1]);
    end
    n_chk++;
    if (rx_cnt[1] !== 12 || done_cnt[1] !== 1 || en_cnt[1] !== 4) begin
      n_fail++;
      $display("FAIL ign_counts: bytes %0d done %0d en %0d, want 12 1 4", rx_cnt[1], done_cnt[1], en_cnt[1]);
    end
    wait_done(1, ok);
    @(negedge clk);
    n_chk++;
    if (!ok || rx_cnt[1] !== 24 || done_cnt[1] !== 2) begin
      n_fail++;
      $display("FAIL ign_second: done %b bytes %0d frames %0d, want 1 24 2", ok, rx_cnt[1], done_cnt[1]);
    end
    for (int k = 0; k < 12; k++) begin
      n_chk++;
      if (rx_mem[1][12 + k] !== exp_byte(k)) begin
        n_fail++;
        $display("FAIL ign_byte %0d: got %h want %h", k, rx_mem[1][12 + k], exp_byte(k));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int k = 0;
    do_clr();
    pulse_start(1);
    while (rx_cnt[1] < 5 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (status_w[1] !== 3'd0 || tx_start_w[1] !== 1'b0 || busy_w[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: status %0d tx_start %b busy %b, want 0 0 0", status_w[1], tx_start_w[1], busy_w[1]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (done_cnt[1] !== 0 || rx_cnt[1] !== 5) begin
      n_fail++;
      $display("FAIL rst_mid_nodone: done %0d bytes %0d, want 0 5", done_cnt[1], rx_cnt[1]);
    end
    do_clr();
    pulse_start(1);
    wait_done(1, ok);
    @(negedge clk);
    n_chk++;
    if (!ok || rx_cnt[1] !== 12) begin
      n_fail++;
      $display("FAIL rst_resend_counts: done %b bytes %0d, want 1 12", ok, rx_cnt[1]);
    end
    for (int b = 0; b < 12; b++) begin
      n_chk++;
      if (rx_mem[1][b] !== exp_byte(b)) begin
        n_fail++;
        $display("FAIL rst_resend_byte %0d: got %h want %h", b, rx_mem[1][b], exp_byte(b));
      end
    end
  endtask

  initial begin
    mem[0] = 24'h112233; mem[1] = 24'h445566; mem[2] = 24'h778899; mem[3] = 24'hAABBCC;
    for (int g = 0; g < 3; g++) begin
      start_w[g] = 1'b0;
      hold[g]    = 1'b0;
    end
    rnd_mode = 1'b0;
    clr      = 1'b1;
    rst_n    = 1'b0;
    test_reset();
    test_frame();
    test_latency();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/read_controller.md
Name: read_controller

Overview:
Frame read-back engine for the image processor. It is the transmit-side counterpart of the UART-to-BRAM pixel writer. On a start pulse it walks the 24-bit pixel BRAM from address 0 to NUM_PIXELS-1 and splits each pixel into 3 bytes, MSB first. Each byte goes to the UART transmitter through a start/busy handshake. It sits between the pixel BRAM read port and uart_tx.

Parameters:
NUM_PIXELS, 196608, pixels per frame; last address is NUM_PIXELS-1
ADDR_W, 18, BRAM address width
RD_LATENCY, 2, BRAM read latency in cycles from the en cycle to valid dout (range 1..3)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse to begin frame read-back; ignored unless in IDLE
dout  in  24  BRAM read data
tx_busy  in  1  UART transmitter busy; high while a byte is being sent
en  out  1  BRAM enable
we  out  1  BRAM write enable; tied 0
addr  out  ADDR_W  BRAM address
tx_start  out  1  one-cycle pulse requesting transmission of tx_data
tx_data  out  8  byte to transmit, registered
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the last byte of the frame is handed off
status  out  3  current state encoding, for debug

Behaviour:
- Reset (rst_n=0, async): state=IDLE; addr=0, en=0, we=0, tx_start=0, tx_data=0, busy=0, done=0.
- Internal registers:
  - pixel register (24 bits)
  - byte index (2 bits: 0,1,2)
  - latency counter (2 bits)
- All outputs are registered except we (const 0) and status (= state).
- States: IDLE, READ, LATCH, SEND, WAIT_TX, NEXT.
- IDLE: addr=0, en=0. When start=1, go to READ and set busy=1.
- READ: en=1 for exactly one cycle at the current addr. Clear the latency counter and go to LATCH.
- LATCH: count cycles. In the RD_LATENCY-th cycle after the en cycle, capture dout into the pixel register, clear the byte index and go to SEND. dout must not be captured earlier.
- SEND: wait while tx_busy=1. When tx_busy=0:
  - drive tx_start=1 for one cycle;
  - in the same cycle drive tx_data = pixel[23:16], [15:8] or [7:0] for index 0, 1, 2;
  - go to WAIT_TX.
- tx_data holds its value until the next tx_start.
- WAIT_TX: ignore tx_busy in the first cycle, which is the uart_tx turnaround. Then wait for tx_busy=0 and go to NEXT.
- NEXT (one cycle):
  - If index<2: increment the index and go to SEND.
  - Else if addr==NUM_PIXELS-1: set addr=0, pulse done=1, set busy=0, go to IDLE.
  - Else: addr=addr+1, go to READ.
- Byte order on the line per pixel is R=[23:16], G=[15:8], B=[7:0]. This is the same order the writer consumes, so a round-trip reproduces the image.
- tx_start never asserts while tx_busy=1. There is at most one outstanding byte.
- start during busy=1 is ignored, with no restart and no queueing. start in the same cycle as done is ignored; a new start is accepted from the next cycle.
- addr never exceeds NUM_PIXELS-1 and wraps to 0 only at frame end.
- rst_n asserted mid-frame aborts immediately to the reset values. tx_start is low in the next cycle. No done pulse is generated.
- Frame output is exactly 3*NUM_PIXELS tx_start pulses and NUM_PIXELS en pulses.

Test Plan:
1. Reset values: hold rst_n=0, then release. Required: all outputs 0 and status=IDLE. Pulse rst_n low mid-cycle: outputs clear asynchronously.
2. Single-frame small (NUM_PIXELS=4, RD_LATENCY=2): BRAM model holds 0x112233, 0x445566, 0x778899, 0xAABBCC; tx model keeps busy 10 cycles per byte. Required: bytes 11 22 33 44 55 66 77 88 99 AA BB CC in order, en pulses at addr 0..3, then done=1 for 1 cycle and addr=0.
3. Latency sweep: RD_LATENCY=1 and 3 with the matching BRAM model. Required: the correct bytes are captured; a capture one cycle early would produce X/wrong data and must be flagged.
4. Backpressure: tx_busy held high 50 cycles before the first byte and randomly afterwards. Required: tx_start never coincides with tx_busy=1 and no byte is dropped or duplicated.
5. start pulsed during an active frame and coincident with done. Required: both are ignored and the frame count is unchanged; a start one cycle after done begins a new frame at addr 0.
6. Reset mid-frame: rst_n low at byte 5. Required: immediate IDLE, no done pulse; a following start re-sends from 0x11.
